cpu_step_ctrl: RTL
==================

// Module: cpu_step_ctrl
// PURPOSE
//  Clock-enable controller upstream of the pipeline CPU; drives the CPU's single-cycle advance enable.
//  Generates one-cycle cpu_ce pulses from clk_src, either periodically (RUN) or one per button press (PAUSE/step).
//  Raw board buttons are synchronised and debounced. Keeps the whole design in the clk_src domain.
//  Also counts issued enables for LED/debug display.
// PARAMETERS
//  DIV_MAX          33554431  RUN-mode enable period minus 1, in clk_src cycles (2^25 cycles)
//  DEBOUNCE_CYCLES  480000    consecutive stable cycles before a button level is accepted (10 ms @ 48 MHz)
//  CNT_W            16        width of ce_count
// PORTS
//  clk_src    in   1      HFOSC clock; all logic on its posedge
//  reset      in   1      synchronous, active-high
//  btn_mode   in   1      raw async button, active-high: toggles RUN/PAUSE on press
//  btn_step   in   1      raw async button, active-high: issues one enable on press while paused
//  cpu_ce     out  1      one-cycle CPU advance enable
//  running    out  1      1 = RUN state, 0 = PAUSE/STEP
//  ce_count   out  CNT_W  number of cpu_ce pulses issued, wraps
// BEHAVIOUR
//  Reset: reset is synchronous, active-high; clock is clk_src. Reset values: cpu_ce=0, running=1, ce_count=0,
//   state=RUN, divider=0, sync FFs=0, debounced levels=0, debounce counters=0. Reset asserted mid-operation
//   restores all of these on the next edge; a pending step or press in flight is dropped.
//  Input path, each button: 2-FF synchroniser -> debouncer -> press detector.
//   Debouncer: counter resets whenever the synced level differs from the debounced level. When it
//   reaches DEBOUNCE_CYCLES-1 with the level still differing, the debounced level takes the new value.
//   Press = one-cycle pulse on a debounced 0->1 transition. Release generates nothing.
//  FSM states:
//   RUN        -> PAUSE on mode_press; step_press ignored
//   PAUSE      -> RUN on mode_press; else -> STEP on step_press
//   STEP       one cycle only -> PAUSE unconditionally; presses in this cycle ignored
//  Simultaneous mode_press and step_press in PAUSE: mode wins (-> RUN), no step.
//  Divider (in RUN only): increments each cycle and wraps DIV_MAX -> 0. Cleared to 0 on every transition
//   into RUN and held at 0 outside RUN.
//  cpu_ce is registered: cpu_ce <= (state==RUN && divider==DIV_MAX) || (state==STEP).
//   First cycle with reset low is cycle 0. In RUN, cpu_ce is high exactly in cycles k*(DIV_MAX+1), k>=1,
//   each time for one cycle.
//   mode_press on the same cycle as divider==DIV_MAX: the pulse is still issued, then the FSM is in PAUSE.
//   STEP state -> cpu_ce high in the following cycle, exactly once per press.
//  running <= (next state == RUN), registered.
//  ce_count increments by 1 in the same cycle cpu_ce is high. Wraps 2^CNT_W-1 -> 0.
//  Step latency from raw btn_step rise, clean input: 2 (sync) + DEBOUNCE_CYCLES (debounce) + 1 (press)
//   + 1 (STEP) + 1 (ce reg) cycles.
//   The bench measures this exact value and requires it to be fixed.
// TESTING (DIV_MAX=9, DEBOUNCE_CYCLES=4, CNT_W=4)
//  1. Release reset, no buttons -> cpu_ce high in cycles 10,20,30 only; running=1; ce_count=3 at cycle 31.
//  2. Pulse btn_mode high for 8 cycles -> running=0 after debounce latency.
//     No cpu_ce while paused; divider held at 0.
//  3. Paused, hold btn_step high 8 cycles -> exactly one cpu_ce, at the measured fixed latency after the rise;
//     ce_count +1. Holding it longer gives no repeat.
//  4. Paused, btn_step toggling every 2 cycles (bounce) for 20 cycles, then stable high -> exactly one cpu_ce.
//  5. Paused, btn_mode and btn_step rise same cycle -> running=1, no step pulse.
//     Next cpu_ce is 10 cycles after the RUN entry.
//  6. Run 16 pulses -> ce_count wraps 15->0. Then assert reset mid-period -> next cycle all outputs at reset
//     values, and the pulse schedule restarts from cycle 0.

Source files
------------

// File: rtl/cpu_step_ctrl_if.sv
// Button inputs and CPU-enable outputs of the step controller.
// The board/bench side uses the master modport; the controller uses the slave modport.
interface cpu_step_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             btn_mode;
  logic             btn_step;
  logic             cpu_ce;
  logic             running;
  logic [CNT_W-1:0] ce_count;

  modport master (
    output btn_mode,
    output btn_step,
    input  cpu_ce,
    input  running,
    input  ce_count
  );

  modport slave (
    input  btn_mode,
    input  btn_step,
    output cpu_ce,
    output running,
    output ce_count
  );
endinterface

// File: rtl/cpu_step_ctrl.sv
// Clock-enable controller for the pipeline CPU: periodic enables in RUN, one enable per
// debounced step press in PAUSE, plus a wrapping count of issued enables.
module cpu_step_ctrl #(
  parameter int DIV_MAX         = 33554431,
  parameter int DEBOUNCE_CYCLES = 480000,
  parameter int CNT_W           = 16
) (
  input  logic            clk_src,
  input  logic            reset,
  cpu_step_ctrl_if.slave  bus
);

  localparam int DIV_W = $clog2(DIV_MAX + 1);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_MAX);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PAUSE = 2'd1,
    ST_STEP  = 2'd2
  } state_t;

  // Button lanes: index 0 is mode, index 1 is step.
  logic [1:0]       raw_s;
  logic [1:0]       sync1_r;
  logic [1:0]       sync2_r;
  logic [1:0]       deb_r;
  logic [1:0]       deb_d_r;
  logic [1:0]       press_r;
  logic [DB_W-1:0]  db_cnt_r [2];

  state_t           state_r;
  logic [DIV_W-1:0] div_r;
  logic             cpu_ce_r;
  logic             running_r;
  logic [CNT_W-1:0] ce_count_r;
  logic             ce_next_s;
  logic             mode_press_s;
  logic             step_press_s;

  assign raw_s        = {bus.btn_step, bus.btn_mode};
  assign mode_press_s = press_r[0];
  assign step_press_s = press_r[1];

  // Synchronise, debounce and edge-detect both buttons.
  always_ff @(posedge clk_src) begin
    if (reset) begin
      sync1_r <= 2'b00;
      sync2_r <= 2'b00;
      deb_r   <= 2'b00;
      deb_d_r <= 2'b00;
      press_r <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        db_cnt_r[i] <= '0;
      end
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
      deb_d_r <= deb_r;
      press_r <= deb_r & ~deb_d_r;
      for (int i = 0; i < 2; i++) begin
        if (sync2_r[i] != deb_r[i]) begin
          if (db_cnt_r[i] == DB_LAST) begin
            deb_r[i]    <= sync2_r[i];
            db_cnt_r[i] <= '0;
          end else begin
            db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
          end
        end else begin
          db_cnt_r[i] <= '0;
        end
      end
    end
  end

  // Enable to be registered this edge; also drives the counter increment.
  always_comb begin
    ce_next_s = 1'b0;
    if (state_r == ST_STEP) begin
      ce_next_s = 1'b1;
    end else begin
      ce_next_s = (state_r == ST_RUN) && (div_r == DIV_LAST);
    end
  end

  // RUN/PAUSE/STEP state machine with divider and registered outputs.
  always_ff @(posedge clk_src) begin
    if (reset) begin
      state_r    <= ST_RUN;
      div_r      <= '0;
      cpu_ce_r   <= 1'b0;
      running_r  <= 1'b1;
      ce_count_r <= '0;
    end else begin
      cpu_ce_r <= ce_next_s;
      if (ce_next_s) begin
        ce_count_r <= ce_count_r + CNT_W'(1);
      end
      case (state_r)
        ST_RUN: begin
          if (mode_press_s) begin
            state_r   <= ST_PAUSE;
            div_r     <= '0;
            running_r <= 1'b0;
          end else begin
            div_r     <= (div_r == DIV_LAST) ? '0 : div_r + DIV_W'(1);
            running_r <= 1'b1;
          end
        end
        ST_PAUSE: begin
          div_r <= '0;
          // Mode has priority over a simultaneous step press.
          if (mode_press_s) begin
            state_r   <= ST_RUN;
            running_r <= 1'b1;
          end else if (step_press_s) begin
            state_r   <= ST_STEP;
            running_r <= 1'b0;
          end else begin
            running_r <= 1'b0;
          end
        end
        ST_STEP: begin
          state_r   <= ST_PAUSE;
          div_r     <= '0;
          running_r <= 1'b0;
        end
        default: begin
          state_r   <= ST_PAUSE;
          div_r     <= '0;
          running_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cpu_ce   = cpu_ce_r;
  assign bus.running  = running_r;
  assign bus.ce_count = ce_count_r;

endmodule
